// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, requester
// indices and a one-hot helper.
package cpu_mem_pkg;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_LOAD  = 2;
  localparam int NUM_REQ   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. Fixed priority loader > data > fetch by
// default; round-robin from (last_winner+1) mod 3 when MEM_ARBITER_RR_EN is defined.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last_winner,
  output logic [NUM_REQ-1:0] o_winner_oh,
  output logic [1:0]         o_winner_idx
);

`ifndef MEM_ARBITER_RR_EN
  // Fixed priority ignores the pointer input.
  logic w_unused_last;
  assign w_unused_last = ^i_last_winner;
`endif

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    o_winner_idx = 2'd0;
`ifdef MEM_ARBITER_RR_EN
    // Walk from farthest to nearest candidate; the last hit is the nearest one.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[(int'(i_last_winner) + k) % NUM_REQ])
        o_winner_idx = 2'((int'(i_last_winner) + k) % NUM_REQ);
    end
`else
    if (i_req[REQ_LOAD])      o_winner_idx = 2'(REQ_LOAD);
    else if (i_req[REQ_DATA]) o_winner_idx = 2'(REQ_DATA);
    else                      o_winner_idx = 2'(REQ_FETCH);
`endif
    o_winner_oh = (|i_req) ? idx_to_onehot(o_winner_idx) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester single-port memory arbiter with IDLE/ACCESS/WAIT/RESP FSM.
// Define MEM_ARBITER_RR_EN for round-robin arbitration instead of fixed priority.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [1:0]         r_win_idx;
  logic               r_we;
  logic [1:0]         w_last;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [1:0]         w_win_idx;

`ifdef MEM_ARBITER_RR_EN
  logic [1:0] r_last;
  assign w_last = r_last;
`else
  assign w_last = 2'(REQ_LOAD);
`endif

  mem_arb_pick u_pick (
    .i_req         (req),
    .i_last_winner (w_last),
    .o_winner_oh   (w_win_oh),
    .o_winner_idx  (w_win_idx)
  );

  assign busy = (r_state != IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_win_idx <= '0;
      r_we      <= 1'b0;
      rdata     <= '0;
      gnt       <= '0;
      done      <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last    <= 2'(REQ_LOAD);
`endif
    end else begin
      gnt    <= '0;
      done   <= '0;
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_win_idx <= w_win_idx;
            r_we      <= we[w_win_idx];
            mem_addr  <= addr[w_win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[w_win_idx*DATA_W +: DATA_W];
            gnt       <= w_win_oh;
            mem_rd    <= ~we[w_win_idx];
            mem_wr    <= we[w_win_idx];
            r_state   <= ACCESS;
`ifdef MEM_ARBITER_RR_EN
            r_last    <= w_win_idx;
`endif
          end
        end
        ACCESS: begin
          r_cnt <= LAT_M1;
          if (LAT_M1 != 4'd0) begin
            r_state <= WAIT;
          end else begin
            r_state <= RESP;
            done    <= idx_to_onehot(r_win_idx);
          end
        end
        WAIT: begin
          // Leave on the cycle the decremented count reaches zero.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            done    <= idx_to_onehot(r_win_idx);
          end
        end
        RESP: begin
          if (!r_we) rdata <= mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
